// File: rtl/lock_pkg.sv
// Shared definitions for the XOR-locked adder key loader and its operand stage.
package lock_pkg;

  localparam int LOCK_KEY_W  = 32;
  localparam int LOCK_CHK_W  = 8;
  localparam int LOCK_DATA_W = 16;
  // Widest key the checksum helper accepts; narrower keys are zero-extended.
  localparam int KEY_MAX_W   = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_CHECK = 3'd2,
    ST_ARMED = 3'd3,
    ST_ERROR = 3'd4
  } key_state_t;

  function automatic logic [7:0] key_checksum(input logic [KEY_MAX_W-1:0] key,
                                              input int n_bytes);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < KEY_MAX_W / 8; i++) begin
      if (i < n_bytes) begin
        acc = acc ^ key[8*i +: 8];
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/lock_op_pipe_reg.sv
// Single valid/ready register slice with an enable gate and a flush that drops
// the held beat; data may stay stale after a flush.
module lock_op_pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         enable_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_ready;
  logic         w_xfer;

  assign w_ready     = enable_i & (~r_valid | out_ready_i);
  assign w_xfer      = in_valid_i & w_ready;
  assign in_ready_o  = w_ready;
  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;

  // Valid bit and payload: flush wins, then fill, then drain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_xfer) begin
        r_valid <= 1'b1;
      end else if (out_ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_xfer && !flush_i) begin
        r_data <= in_data_i;
      end
    end
  end

endmodule

// File: rtl/lock_key_loader_opstage.sv
// Serial unlock-key loader with checksum verification, plus the gated operand
// register feeding the XOR-locked carry-lookahead adder.
module lock_key_loader_opstage
  import lock_pkg::*;
#(
  parameter int KEY_W  = LOCK_KEY_W,
  parameter int CHK_W  = LOCK_CHK_W,
  parameter int DATA_W = LOCK_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              key_load_i,
  input  logic              key_shift_en_i,
  input  logic              key_sdi_i,
  output logic              key_valid_o,
  output logic              key_err_o,
  output logic [KEY_W-1:0]  keyinput_o,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [DATA_W-1:0] add1_i,
  input  logic [DATA_W-1:0] add2_i,
  output logic              op_valid_o,
  input  logic              op_ready_i,
  output logic [DATA_W-1:0] add1_o,
  output logic [DATA_W-1:0] add2_o
);

  localparam int SR_W  = KEY_W + CHK_W;
  localparam int CNT_W = $clog2(SR_W + 1);

  key_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SR_W-1:0]    r_sr;
  logic [KEY_W-1:0]   r_key;
  logic               r_key_valid;
  logic               r_key_err;

  logic               w_last_bit;
  logic               w_chk_ok;
  logic               w_flush;
  logic [2*DATA_W-1:0] w_op_in;
  logic [2*DATA_W-1:0] w_op_out;

  assign w_last_bit = (r_cnt == CNT_W'(SR_W - 1));
  assign w_chk_ok   = (key_checksum(KEY_MAX_W'(r_sr[KEY_W-1:0]), KEY_W / 8)
                       == r_sr[SR_W-1 -: CHK_W]);

  // Key FSM: a load pulse overrides everything and restarts shifting from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
    end else if (key_load_i) begin
      r_state     <= ST_SHIFT;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        ST_SHIFT: begin
          if (key_shift_en_i) begin
            // LSB first: the first bit received ends up at bit 0.
            r_sr  <= {key_sdi_i, r_sr[SR_W-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last_bit) begin
              r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (w_chk_ok) begin
            r_key       <= r_sr[KEY_W-1:0];
            r_key_valid <= 1'b1;
            r_state     <= ST_ARMED;
          end else begin
            r_key_err   <= 1'b1;
            r_state     <= ST_ERROR;
          end
        end
        ST_ARMED: begin
          r_state <= ST_ARMED;
        end
        ST_ERROR: begin
          r_state <= ST_ERROR;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign key_valid_o = r_key_valid;
  assign key_err_o   = r_key_err;
  assign keyinput_o  = r_key;

  // A reload or an unarmed key drops any beat held for the adder.
  assign w_flush = key_load_i | ~r_key_valid;
  assign w_op_in = {add1_i, add2_i};

  lock_op_pipe_reg #(
    .W (2 * DATA_W)
  ) u_op_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (w_flush),
    .enable_i    (r_key_valid),
    .in_valid_i  (op_valid_i),
    .in_ready_o  (op_ready_o),
    .in_data_i   (w_op_in),
    .out_valid_o (op_valid_o),
    .out_ready_i (op_ready_i),
    .out_data_o  (w_op_out)
  );

  assign add1_o = w_op_out[2*DATA_W-1:DATA_W];
  assign add2_o = w_op_out[DATA_W-1:0];

endmodule

// File: tb/tb_lock_key_loader_opstage.sv
// Self-checking bench: table of key loads, hand-written operand sequences,
// then randomized traffic against a cycle-level behavioural model.
module tb_lock_key_loader_opstage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        key_load_i;
  logic        key_shift_en_i;
  logic        key_sdi_i;
  logic        key_valid_o;
  logic        key_err_o;
  logic [31:0] keyinput_o;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [15:0] add1_i;
  logic [15:0] add2_i;
  logic        op_valid_o;
  logic        op_ready_i;
  logic [15:0] add1_o;
  logic [15:0] add2_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  lock_key_loader_opstage dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .key_load_i     (key_load_i),
    .key_shift_en_i (key_shift_en_i),
    .key_sdi_i      (key_sdi_i),
    .key_valid_o    (key_valid_o),
    .key_err_o      (key_err_o),
    .keyinput_o     (keyinput_o),
    .op_valid_i     (op_valid_i),
    .op_ready_o     (op_ready_o),
    .add1_i         (add1_i),
    .add2_i         (add2_i),
    .op_valid_o     (op_valid_o),
    .op_ready_i     (op_ready_i),
    .add1_o         (add1_o),
    .add2_o         (add2_o)
  );

  typedef struct packed {
    logic [31:0] key;
    logic [7:0]  chk;
    logic        gaps;
    logic        exp_valid;
    logic        exp_err;
  } kvec_t;

  kvec_t vecs [6];

  // Behavioural model state
  logic        m_loading, m_pending, m_valid, m_err, m_opv;
  int          m_nbits;
  logic [39:0] m_acc;
  logic [31:0] m_key;
  logic [15:0] m_a, m_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] ref_checksum(input logic [31:0] k);
    logic [7:0] x;
    x = 8'h00;
    for (int b = 0; b < 4; b++) x = x ^ 8'((k >> (8 * b)) & 32'hFF);
    return x;
  endfunction

  // Pulses key_load_i, streams 40 bits LSB first and stops right after the
  // edge that accepts the last bit; the caller steps once more to see ARMED/ERROR.
  task automatic load_key(input logic [31:0] key, input logic [7:0] c, input logic gaps);
    logic [39:0] w;
    w = {c, key};
    key_load_i = 1'b1; key_shift_en_i = 1'b1; key_sdi_i = 1'b1;
    step();
    key_load_i = 1'b0;
    chk("load_clears_err", key_err_o, 1'b0);
    chk("load_clears_valid", key_valid_o, 1'b0);
    chk("load_clears_key", keyinput_o, 32'h0);
    for (int i = 0; i < 40; i++) begin
      if (gaps && (i % 5 == 2)) begin
        key_shift_en_i = 1'b0;
        step();
      end
      key_shift_en_i = 1'b1;
      key_sdi_i = w[i];
      step();
      if (i == 20) chk("no_partial_key", keyinput_o, 32'h0);
    end
    chk("valid_not_early", key_valid_o, 1'b0);
    key_shift_en_i = 1'b1;
    key_sdi_i = 1'b1;
  endtask

  task automatic m_reset();
    m_loading = 0; m_pending = 0; m_valid = 0; m_err = 0; m_opv = 0;
    m_nbits = 0; m_acc = '0; m_key = '0; m_a = '0; m_b = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic m_step();
    logic rdy;
    rdy = m_valid && (!m_opv || op_ready_i);
    if (rst_i) begin
      m_reset();
    end else begin
      if (key_load_i || !m_valid) m_opv = 0;
      else if (op_valid_i && rdy) begin m_opv = 1; m_a = add1_i; m_b = add2_i; end
      else if (op_ready_i) m_opv = 0;
      if (key_load_i) begin
        m_loading = 1; m_pending = 0; m_nbits = 0; m_acc = '0;
        m_key = '0; m_valid = 0; m_err = 0;
      end else if (m_pending) begin
        m_pending = 0;
        if (ref_checksum(m_acc[31:0]) == m_acc[39:32]) begin
          m_key = m_acc[31:0]; m_valid = 1;
        end else begin
          m_err = 1;
        end
      end else if (m_loading && key_shift_en_i) begin
        m_acc = m_acc | (40'(key_sdi_i) << m_nbits);
        m_nbits++;
        if (m_nbits == 40) begin m_loading = 0; m_pending = 1; end
      end
    end
  endtask

  initial begin
    logic [39:0] d_word;
    int          d_idx;
    logic [31:0] rk;
    logic [7:0]  rc;

    vecs[0] = '{32'h12345678, 8'h08, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'h12345678, 8'h09, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'hA5A50F0F, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'h00000000, 8'h01, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'h80000001, 8'h81, 1'b1, 1'b1, 1'b0};

    rst_i = 1'b1; key_load_i = 1'b0; key_shift_en_i = 1'b0; key_sdi_i = 1'b0;
    op_valid_i = 1'b0; op_ready_i = 1'b0; add1_i = '0; add2_i = '0;
    step(); step();
    rst_i = 1'b0;
    op_ready_i = 1'b1; op_valid_i = 1'b1; add1_i = 16'hBEEF; add2_i = 16'hCAFE;
    key_shift_en_i = 1'b1;
    step();
    chk("rst_key_valid", key_valid_o, 1'b0);
    chk("rst_key_err", key_err_o, 1'b0);
    chk("rst_keyinput", keyinput_o, 32'h0);
    chk("rst_op_valid", op_valid_o, 1'b0);
    chk("rst_op_ready", op_ready_o, 1'b0);
    chk("rst_add1", add1_o, 16'h0);
    chk("rst_add2", add2_o, 16'h0);
    op_valid_i = 1'b0; op_ready_i = 1'b0; key_shift_en_i = 1'b0;

    for (int v = 0; v < 6; v++) begin
      load_key(vecs[v].key, vecs[v].chk, vecs[v].gaps);
      step();
      key_shift_en_i = 1'b0;
      chk("tbl_key_valid", key_valid_o, vecs[v].exp_valid);
      chk("tbl_key_err", key_err_o, vecs[v].exp_err);
      chk("tbl_keyinput", keyinput_o, vecs[v].exp_valid ? 64'(vecs[v].key) : 64'h0);
      op_ready_i = 1'b1;
      #1;
      chk("tbl_op_ready", op_ready_o, vecs[v].exp_valid);
      op_ready_i = 1'b0;
      key_shift_en_i = 1'b1; key_sdi_i = 1'b0;
      step(); step();
      key_shift_en_i = 1'b0;
      chk("tbl_key_hold", keyinput_o, vecs[v].exp_valid ? 64'(vecs[v].key) : 64'h0);
    end

    // Back-to-back operands at full throughput
    load_key(32'h12345678, 8'h08, 1'b0);
    step();
    key_shift_en_i = 1'b0;
    op_ready_i = 1'b1; op_valid_i = 1'b1; add1_i = 16'h00FF; add2_i = 16'h0001;
    #1;
    chk("tp_ready0", op_ready_o, 1'b1);
    step();
    chk("tp_valid1", op_valid_o, 1'b1);
    chk("tp_add1_1", add1_o, 16'h00FF);
    chk("tp_add2_1", add2_o, 16'h0001);
    add1_i = 16'hFFFF; add2_i = 16'hFFFF;
    #1;
    chk("tp_ready1", op_ready_o, 1'b1);
    step();
    chk("tp_valid2", op_valid_o, 1'b1);
    chk("tp_add1_2", add1_o, 16'hFFFF);
    chk("tp_add2_2", add2_o, 16'hFFFF);
    op_valid_i = 1'b0;
    step();
    chk("tp_drain", op_valid_o, 1'b0);

    // Backpressure holds data
    op_valid_i = 1'b1; add1_i = 16'h1234; add2_i = 16'h4321;
    step();
    op_ready_i = 1'b0; add1_i = 16'h5555; add2_i = 16'h6666;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", op_ready_o, 1'b0);
      chk("bp_valid", op_valid_o, 1'b1);
      chk("bp_add1", add1_o, 16'h1234);
      chk("bp_add2", add2_o, 16'h4321);
      step();
    end
    op_ready_i = 1'b1; op_valid_i = 1'b0;
    step();
    chk("bp_release", op_valid_o, 1'b0);

    // Reload while armed with a held beat flushes it
    op_valid_i = 1'b1; op_ready_i = 1'b0;
    step();
    chk("fl_pre_valid", op_valid_o, 1'b1);
    op_valid_i = 1'b0;
    key_load_i = 1'b1;
    step();
    key_load_i = 1'b0;
    chk("fl_keyinput", keyinput_o, 32'h0);
    chk("fl_key_valid", key_valid_o, 1'b0);
    chk("fl_op_valid", op_valid_o, 1'b0);
    // Already in SHIFT: a bare 40-bit stream must arm the key.
    begin
      logic [39:0] w;
      w = {8'h81, 32'h80000001};
      for (int i = 0; i < 40; i++) begin
        key_shift_en_i = 1'b1; key_sdi_i = w[i];
        step();
      end
      key_shift_en_i = 1'b0;
      step();
      chk("fl_shift_state", keyinput_o, 32'h80000001);
    end

    // Reset mid-load, then a clean load
    key_load_i = 1'b1;
    step();
    key_load_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      key_shift_en_i = 1'b1; key_sdi_i = 1'b1;
      step();
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    key_shift_en_i = 1'b0;
    chk("mr_keyinput", keyinput_o, 32'h0);
    chk("mr_key_valid", key_valid_o, 1'b0);
    load_key(32'hA5A50F0F, 8'h00, 1'b0);
    step();
    key_shift_en_i = 1'b0;
    chk("mr_valid", key_valid_o, 1'b1);
    chk("mr_key", keyinput_o, 32'hA5A50F0F);
    chk("mr_err", key_err_o, 1'b0);

    // Randomized traffic against the model
    rst_i = 1'b1; key_load_i = 1'b0; op_valid_i = 1'b0;
    step();
    m_reset();
    d_word = '0; d_idx = 40;
    for (int c = 0; c < 4000; c++) begin
      rst_i = ($urandom_range(0, 599) == 0);
      key_load_i = !rst_i && ((c == 0) || ($urandom_range(0, 59) == 0));
      if (key_load_i) begin
        rk = $urandom;
        rc = ref_checksum(rk);
        if ($urandom_range(0, 3) == 0) rc = rc ^ 8'(1 << $urandom_range(0, 7));
        d_word = {rc, rk}; d_idx = 0;
        key_shift_en_i = 1'($urandom_range(0, 1));
        key_sdi_i = 1'($urandom_range(0, 1));
      end else begin
        key_shift_en_i = ($urandom_range(0, 2) != 0);
        key_sdi_i = (d_idx < 40) ? d_word[d_idx] : 1'($urandom_range(0, 1));
        if (key_shift_en_i && d_idx < 40) d_idx++;
      end
      if (rst_i) d_idx = 40;
      op_valid_i = 1'($urandom_range(0, 1));
      op_ready_i = ($urandom_range(0, 9) < 7);
      add1_i = 16'($urandom);
      add2_i = 16'($urandom);
      #1;
      chk("rnd_op_ready", op_ready_o, m_valid && (!m_opv || op_ready_i));
      m_step();
      step();
      chk("rnd_key_valid", key_valid_o, m_valid);
      chk("rnd_key_err", key_err_o, m_err);
      chk("rnd_keyinput", keyinput_o, m_key);
      chk("rnd_op_valid", op_valid_o, m_opv);
      if (m_opv) begin
        chk("rnd_add1", add1_o, m_a);
        chk("rnd_add2", add2_o, m_b);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
